// File: rtl/complex_demulp.sv
// Inverse phase rotator: (in_r + j*in_i) * (cos - j*sin), one shared multiplier over 4 cycles.
// Build option DEROT_ROUND_EN: round half toward +inf instead of truncating toward -inf.
module complex_demulp #(
    parameter int unsigned IN_W     = 13,
    parameter int unsigned COEF_W   = 12,
    parameter int unsigned OUT_W    = 8,
    parameter int unsigned FRAC_SUM = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [IN_W-1:0]   in_r,
    input  logic signed [IN_W-1:0]   in_i,
    input  logic signed [COEF_W-1:0] cos_2p_by,
    input  logic signed [COEF_W-1:0] sin_2p_by,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_r,
    output logic signed [OUT_W-1:0]  out_i,
    output logic                     out_sat
);

    localparam int unsigned PROD_W = IN_W + COEF_W;
    localparam int unsigned ACC_W  = PROD_W + 1;
    localparam int unsigned EXT_W  = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-(2 ** (OUT_W - 1)));
`ifdef DEROT_ROUND_EN
    localparam logic signed [EXT_W-1:0] RND_HALF = EXT_W'(2 ** (FRAC_SUM - 1));
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        OUT  = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [1:0]                k_q, k_d;
    logic signed [IN_W-1:0]    op_r_q, op_r_d, op_i_q, op_i_d;
    logic signed [COEF_W-1:0]  cos_q, cos_d, sin_q, sin_d;
    logic signed [ACC_W-1:0]   acc_r_q, acc_r_d, acc_i_q, acc_i_d;
    logic                      in_ready_q, in_ready_d;
    logic                      out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0]   out_r_q, out_r_d, out_i_q, out_i_d;
    logic                      out_sat_q, out_sat_d;

    logic signed [IN_W-1:0]    mul_a_c;
    logic signed [COEF_W-1:0]  mul_b_c;
    logic signed [PROD_W-1:0]  prod_c;
    logic signed [ACC_W-1:0]   prod_ext_c;
    logic signed [ACC_W-1:0]   acc_i_fin_c;
    logic [OUT_W:0]            res_r_c, res_i_c;

    // Scale a Q10.15 accumulator to an integer and clamp; MSB of the result flags a clamp.
    function automatic logic [OUT_W:0] scale_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [EXT_W-1:0] ext;
        logic signed [EXT_W-1:0] sh;
        ext = $signed({acc[ACC_W-1], acc});
`ifdef DEROT_ROUND_EN
        ext = ext + RND_HALF;
`endif
        sh = ext >>> FRAC_SUM;
        if (sh > SAT_MAX) begin
            return {1'b1, SAT_MAX[OUT_W-1:0]};
        end else if (sh < SAT_MIN) begin
            return {1'b1, SAT_MIN[OUT_W-1:0]};
        end
        return {1'b0, sh[OUT_W-1:0]};
    endfunction

    // Operand select for the shared multiplier.
    always_comb begin
        mul_a_c = op_r_q;
        mul_b_c = cos_q;
        unique case (k_q)
            2'd0: begin mul_a_c = op_r_q; mul_b_c = cos_q; end
            2'd1: begin mul_a_c = op_i_q; mul_b_c = sin_q; end
            2'd2: begin mul_a_c = op_i_q; mul_b_c = cos_q; end
            2'd3: begin mul_a_c = op_r_q; mul_b_c = sin_q; end
        endcase
    end

    assign prod_c      = PROD_W'(mul_a_c) * PROD_W'(mul_b_c);
    assign prod_ext_c  = ACC_W'(prod_c);
    assign acc_i_fin_c = acc_i_q - prod_ext_c;
    assign res_r_c     = scale_sat(acc_r_q);
    assign res_i_c     = scale_sat(acc_i_fin_c);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            op_r_q      <= '0;
            op_i_q      <= '0;
            cos_q       <= '0;
            sin_q       <= '0;
            acc_r_q     <= '0;
            acc_i_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_i_q     <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            op_r_q      <= op_r_d;
            op_i_q      <= op_i_d;
            cos_q       <= cos_d;
            sin_q       <= sin_d;
            acc_r_q     <= acc_r_d;
            acc_i_q     <= acc_i_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            out_i_q     <= out_i_d;
            out_sat_q   <= out_sat_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        op_r_d      = op_r_q;
        op_i_d      = op_i_q;
        cos_d       = cos_q;
        sin_d       = sin_q;
        acc_r_d     = acc_r_q;
        acc_i_d     = acc_i_q;
        out_valid_d = out_valid_q;
        out_r_d     = out_r_q;
        out_i_d     = out_i_q;
        out_sat_d   = out_sat_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_r_d  = in_r;
                    op_i_d  = in_i;
                    cos_d   = cos_2p_by;
                    sin_d   = sin_2p_by;
                    acc_r_d = '0;
                    acc_i_d = '0;
                    k_d     = 2'd0;
                    state_d = MUL;
                end
            end
            MUL: begin
                k_d = k_q + 2'd1;
                unique case (k_q)
                    2'd0, 2'd1: acc_r_d = acc_r_q + prod_ext_c;
                    2'd2:       acc_i_d = acc_i_q + prod_ext_c;
                    2'd3: begin
                        acc_i_d     = acc_i_fin_c;
                        out_r_d     = $signed(res_r_c[OUT_W-1:0]);
                        out_i_d     = $signed(res_i_c[OUT_W-1:0]);
                        out_sat_d   = res_r_c[OUT_W] | res_i_c[OUT_W];
                        out_valid_d = 1'b1;
                        state_d     = OUT;
                    end
                endcase
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign out_i     = out_i_q;
    assign out_sat   = out_sat_q;

endmodule
